// File: rtl/move_sequencer_pkg.sv
// rbot_moves_pkg: move code constants, default sizes, sequencer state encoding and the built-in batch table
package rbot_moves_pkg;
  localparam int MOVE_W = 4;
  localparam int MAX_LEN = 50;
  localparam int N_BATCH = 49;
  localparam int IDX_W = 6;
  localparam int LEN_W = 6;
  localparam int MV_R = 2;
  localparam int MV_RI = 3;
  localparam int MV_L = 4;
  localparam int MV_LI = 5;
  localparam int MV_F = 6;
  localparam int MV_FI = 7;
  localparam int MV_U = 8;
  localparam int MV_UI = 9;
  localparam int MV_B = 10;
  localparam int MV_BI = 11;
  localparam int MV_D = 12;
  localparam int MV_DI = 13;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_FIN} state_t;
  function automatic int def_len(input int b);
    return b == 0 ? 0 : b == 1 ? 3 : b == 2 ? MAX_LEN : b == 3 ? 63 : b % 9 + 1;
  endfunction
  function automatic int def_move(input int b, input int s);
    return b == 1 ? (s == 0 ? MV_FI : s == 1 ? MV_R : MV_RI) : MV_R + (b * 5 + s * 3) % 12;
  endfunction
endpackage

// File: rtl/move_sequencer_rom.sv
// move_batch_rom: synchronous batch ROM; clock, i_idx/i_slot address in, o_move (code at slot) and o_len (batch length) out one cycle later
module move_batch_rom #(
  parameter int MOVE_W = 4,
  parameter int MAX_LEN = 50,
  parameter int N_BATCH = 49,
  parameter int IDX_W = 6,
  parameter int LEN_W = 6
) (
  input  logic              clock,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LEN_W-1:0]  i_slot,
  output logic [MOVE_W-1:0] o_move,
  output logic [LEN_W-1:0]  o_len
);
  import rbot_moves_pkg::def_len;
  import rbot_moves_pkg::def_move;
  logic [MOVE_W-1:0] w_mem [N_BATCH][MAX_LEN];
  logic [LEN_W-1:0]  w_len [N_BATCH];
  always_comb
    for (int b = 0; b < N_BATCH; b++) begin
      w_len[b] = LEN_W'(def_len(b));
      for (int s = 0; s < MAX_LEN; s++) w_mem[b][s] = MOVE_W'(def_move(b, s));
    end
  always_ff @(posedge clock) begin
    o_move <= (32'(i_idx) < N_BATCH && 32'(i_slot) < MAX_LEN) ? w_mem[i_idx][i_slot] : '0;
    o_len <= 32'(i_idx) < N_BATCH ? w_len[i_idx] : '0;
  end
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: replays a ROM batch as a move_out/move_valid/move_ready/move_last stream on start+batch_idx, with abort, busy, done, bad_idx and packed_moves/packed_valid
module move_sequencer #(
  parameter int MOVE_W = rbot_moves_pkg::MOVE_W,
  parameter int MAX_LEN = rbot_moves_pkg::MAX_LEN,
  parameter int N_BATCH = rbot_moves_pkg::N_BATCH,
  parameter int IDX_W = rbot_moves_pkg::IDX_W,
  parameter int LEN_W = rbot_moves_pkg::LEN_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IDX_W-1:0]          batch_idx,
  input  logic                      abort,
  output logic [MOVE_W-1:0]         move_out,
  output logic                      move_valid,
  input  logic                      move_ready,
  output logic                      move_last,
  output logic                      busy,
  output logic                      done,
  output logic                      bad_idx,
  output logic [MAX_LEN*MOVE_W-1:0] packed_moves,
  output logic                      packed_valid
);
  import rbot_moves_pkg::state_t;
  import rbot_moves_pkg::S_IDLE;
  import rbot_moves_pkg::S_FETCH;
  import rbot_moves_pkg::S_EMIT;
  import rbot_moves_pkg::S_FIN;
  localparam int PW = MAX_LEN * MOVE_W;
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [LEN_W-1:0] r_len, r_ptr, w_slot, w_rom_len;
  logic [MOVE_W-1:0] w_rom_move;
  logic [PW-1:0] r_pack;
  logic r_bad, w_accept, w_beat, w_abort;
  assign w_accept = r_state == S_IDLE && start && 32'(batch_idx) < N_BATCH;
  assign w_abort = r_state != S_IDLE && abort;
  assign w_beat = r_state == S_EMIT && move_ready && !abort;
  // ROM is addressed one cycle ahead: batch_idx while idle so FETCH sees len, next slot on a beat
  assign w_slot = r_state == S_EMIT ? r_ptr + LEN_W'(w_beat) : '0;
  move_batch_rom #(
    .MOVE_W(MOVE_W), .MAX_LEN(MAX_LEN), .N_BATCH(N_BATCH), .IDX_W(IDX_W), .LEN_W(LEN_W)
  ) u_rom (
    .clock(clock),
    .i_idx(r_state == S_IDLE ? batch_idx : r_idx),
    .i_slot(w_slot),
    .o_move(w_rom_move),
    .o_len(w_rom_len)
  );
  always_comb begin
    w_next = r_state;
    move_valid = r_state == S_EMIT;
    move_out = r_state == S_EMIT ? w_rom_move : '0;
    move_last = r_state == S_EMIT && r_ptr == r_len - LEN_W'(1);
    busy = r_state != S_IDLE;
    done = r_state == S_FIN;
    packed_valid = r_state == S_FIN;
    bad_idx = r_bad;
    packed_moves = r_pack;
    if (w_abort) w_next = S_IDLE;
    else if (r_state == S_IDLE) w_next = w_accept ? S_FETCH : S_IDLE;
    else if (r_state == S_FETCH) w_next = w_rom_len == '0 ? S_FIN : S_EMIT;
    else if (r_state == S_EMIT) w_next = w_beat && move_last ? S_FIN : S_EMIT;
    else w_next = S_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_len <= '0;
      r_ptr <= '0;
      r_pack <= '0;
      r_bad <= 1'b0;
    end else begin
      r_state <= w_next;
      r_bad <= r_state == S_IDLE && start && 32'(batch_idx) >= N_BATCH;
      if (w_accept) begin
        r_idx <= batch_idx;
        r_ptr <= '0;
        r_pack <= '0;
      end
      if (r_state == S_FETCH) r_len <= w_rom_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : w_rom_len;
      if (w_abort) r_pack <= '0;
      else if (w_beat) begin
        r_ptr <= r_ptr + LEN_W'(1);
        r_pack <= (r_pack << MOVE_W) | PW'(w_rom_move);
      end
    end
  end
endmodule
